// File: rtl/intr_sequencer_pkg.sv
// Shared definitions for the interrupt entry sequencer.
// Holds the 3-bit state encoding, default datapath width, default vector
// address and reset values for the capture registers.
// Optional feature macro: INTR_CCR_SAVE_EN (adds the PUSH_CCR state).
package intr_sequencer_pkg;

  localparam int unsigned DataWDefault   = 8;
  localparam logic [7:0]  VecAddrDefault = 8'h01;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDrain   = 3'd1,
    StPushPc  = 3'd2,
    StVecReq  = 3'd4,
    StVecWait = 3'd5,
`ifdef INTR_CCR_SAVE_EN
    StLoadPc  = 3'd6,
    StPushCcr = 3'd3
`else
    StLoadPc  = 3'd6
`endif
  } state_e;

  localparam state_e StateRst  = StIdle;
  localparam logic   InIsrRst  = 1'b0;
  localparam logic   FlagRst   = 1'b0;

endpackage

// File: rtl/intr_sequencer.sv
// Interrupt entry sequencer.
// Turns a pending external interrupt into a hardware entry sequence: stall and
// flush fetch, wait for the pipeline to drain, push the return PC at M[SP]
// (decrementing SP), read the ISR address from M[VEC_ADDR], load it into the
// PC and pulse intr_clear. Tracks ISR residency until RTI retires.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   intr_flag             pending interrupt from the ports block
//   intr_clear            one-cycle clear back to the ports block
//   pc_cur, sp_in         return address and stack pointer sources
//   pipe_empty            pipeline has no pending side effects
//   rti_retire            RTI retired this cycle
//   mem_rdata             data-memory read data (1-cycle latency)
//   stall_fetch, flush_if fetch control
//   mem_req/we/addr/wdata data-memory port ownership and request
//   sp_dec, pc_load       one-cycle SP decrement / PC load pulses
//   pc_load_val           ISR start address
//   in_isr                ISR currently executing
//   ccr_in, ccr_restore   only with INTR_CCR_SAVE_EN: flags to save / restore pulse
//
// Macro INTR_CCR_SAVE_EN: also pushes {4'b0, ccr_in} at M[SP-1] after the PC.
// All outputs decode registered state only; no input-to-output path.
module intr_sequencer
  import intr_sequencer_pkg::*;
#(
  parameter int unsigned         DATA_W   = DataWDefault,
  parameter logic [DATA_W-1:0]   VEC_ADDR = DATA_W'(VecAddrDefault)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr_flag,
  output logic              intr_clear,
  input  logic [DATA_W-1:0] pc_cur,
  input  logic [DATA_W-1:0] sp_in,
  input  logic              pipe_empty,
  input  logic              rti_retire,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef INTR_CCR_SAVE_EN
  input  logic [3:0]        ccr_in,
  output logic              ccr_restore,
`endif
  output logic              stall_fetch,
  output logic              flush_if,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              sp_dec,
  output logic              pc_load,
  output logic [DATA_W-1:0] pc_load_val,
  output logic              in_isr
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ret_pc_q, ret_pc_d;
  logic [DATA_W-1:0] sp_cap_q, sp_cap_d;
  logic [DATA_W-1:0] vec_reg_q, vec_reg_d;
  logic              in_isr_q, in_isr_d;
  // High only during the first DRAIN cycle so flush_if stays a Moore output.
  logic              drain_first_q, drain_first_d;
`ifdef INTR_CCR_SAVE_EN
  logic [3:0]        ccr_cap_q, ccr_cap_d;
  logic              ccr_restore_q, ccr_restore_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StateRst;
      ret_pc_q      <= '0;
      sp_cap_q      <= '0;
      vec_reg_q     <= '0;
      in_isr_q      <= InIsrRst;
      drain_first_q <= FlagRst;
`ifdef INTR_CCR_SAVE_EN
      ccr_cap_q     <= '0;
      ccr_restore_q <= FlagRst;
`endif
    end else begin
      state_q       <= state_d;
      ret_pc_q      <= ret_pc_d;
      sp_cap_q      <= sp_cap_d;
      vec_reg_q     <= vec_reg_d;
      in_isr_q      <= in_isr_d;
      drain_first_q <= drain_first_d;
`ifdef INTR_CCR_SAVE_EN
      ccr_cap_q     <= ccr_cap_d;
      ccr_restore_q <= ccr_restore_d;
`endif
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d       = state_q;
    ret_pc_d      = ret_pc_q;
    sp_cap_d      = sp_cap_q;
    vec_reg_d     = vec_reg_q;
    in_isr_d      = in_isr_q;
    drain_first_d = 1'b0;
`ifdef INTR_CCR_SAVE_EN
    ccr_cap_d     = ccr_cap_q;
    ccr_restore_d = rti_retire && in_isr_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Registered in_isr gates entry: an RTI retiring this cycle only
        // lets the pending flag in on the following cycle.
        if (intr_flag && !in_isr_q) begin
          state_d       = StDrain;
          ret_pc_d      = pc_cur;
          drain_first_d = 1'b1;
        end
      end
      StDrain: begin
        if (pipe_empty) begin
          state_d  = StPushPc;
          sp_cap_d = sp_in;
`ifdef INTR_CCR_SAVE_EN
          ccr_cap_d = ccr_in;
`endif
        end
      end
      StPushPc: begin
`ifdef INTR_CCR_SAVE_EN
        state_d = StPushCcr;
`else
        state_d = StVecReq;
`endif
      end
`ifdef INTR_CCR_SAVE_EN
      StPushCcr: state_d = StVecReq;
`endif
      StVecReq:  state_d = StVecWait;
      StVecWait: begin
        vec_reg_d = mem_rdata;
        state_d   = StLoadPc;
      end
      StLoadPc:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    if (rti_retire && in_isr_q) begin
      in_isr_d = 1'b0;
    end
    if (state_q == StLoadPc) begin
      in_isr_d = 1'b1;
    end
  end

  // Moore output decode.
  always_comb begin
    stall_fetch = 1'b0;
    flush_if    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    sp_dec      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    intr_clear  = 1'b0;

    unique case (state_q)
      StIdle: ;
      StDrain: begin
        stall_fetch = 1'b1;
        flush_if    = drain_first_q;
      end
      StPushPc: begin
        stall_fetch = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = sp_cap_q;
        mem_wdata   = ret_pc_q;
        sp_dec      = 1'b1;
      end
`ifdef INTR_CCR_SAVE_EN
      StPushCcr: begin
        stall_fetch = 1'b1;
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = sp_cap_q - DATA_W'(1);
        mem_wdata   = DATA_W'(ccr_cap_q);
        sp_dec      = 1'b1;
      end
`endif
      StVecReq: begin
        stall_fetch = 1'b1;
        mem_req     = 1'b1;
        mem_addr    = VEC_ADDR;
      end
      StVecWait: stall_fetch = 1'b1;
      StLoadPc: begin
        pc_load     = 1'b1;
        pc_load_val = vec_reg_q;
        intr_clear  = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_isr = in_isr_q;
`ifdef INTR_CCR_SAVE_EN
  assign ccr_restore = ccr_restore_q;
`endif

endmodule
